// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;
  localparam PC_INC = 4;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a valid instruction on load, or becomes a bubble on flush.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         flush,
  input  logic [N-1:0] d_pc,
  input  logic [31:0]  d_instr,
  output logic [N-1:0] pc,
  output logic [31:0]  instr,
  output logic         valid
);

  // Flush wins over load so a redirect can never let a wrong-path word through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= d_pc;
      instr <= d_instr;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, stall buffering and branch redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int             N        = 64,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCWrite,
  input  logic         IF_ID_Write,
  input  logic         PCSrc,
  input  logic [N-1:0] PCBranch,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [N-1:0] IF_ID_pc,
  output logic [31:0]  IF_ID_instr,
  output logic         IF_ID_valid
);

  fetch_state_t state;
  logic [N-1:0] pc;
  logic [N-1:0] stale_addr;
  logic [31:0]  hold_word;

  logic         go;
  logic [N-1:0] target;
  logic [N-1:0] pc_inc;
  logic         id_load;
  logic         id_flush;
  logic [31:0]  id_instr;

  assign go     = PCWrite & IF_ID_Write;
  assign target = PCBranch & ~{{(N-2){1'b0}}, 2'b11};
  assign pc_inc = pc + N'(PC_INC);

  // Memory-facing outputs decode registers only, never the ack/rdata inputs.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? stale_addr : pc;

  always_comb begin
    id_load  = 1'b0;
    id_flush = 1'b0;
    id_instr = imem_rdata;
    case (state)
      IDLE:  id_flush = PCSrc;
      FETCH: begin
        if (PCSrc)                 id_flush = 1'b1;
        else if (imem_ack && go)   id_load  = 1'b1;
        else if (!imem_ack && IF_ID_Write) id_flush = 1'b1;
      end
      HOLD: begin
        id_instr = hold_word;
        if (PCSrc)   id_flush = 1'b1;
        else if (go) id_load  = 1'b1;
      end
      DRAIN: id_flush = PCSrc;
      default: id_flush = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      stale_addr <= RESET_PC;
      hold_word  <= '0;
    end else if (PCSrc) begin
      pc        <= target;
      hold_word <= '0;
      // An unacked request must still complete; park its address and drain it.
      if (state == FETCH && !imem_ack) begin
        state      <= DRAIN;
        stale_addr <= pc;
      end else if (state == DRAIN && !imem_ack) begin
        state <= DRAIN;
      end else begin
        state <= FETCH;
      end
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            if (go) begin
              pc <= pc_inc;
            end else begin
              hold_word <= imem_rdata;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (go) begin
            pc    <= pc_inc;
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  if_id_reg #(.N(N)) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load    (id_load),
    .flush   (id_flush),
    .d_pc    (pc),
    .d_instr (id_instr),
    .pc      (IF_ID_pc),
    .instr   (IF_ID_instr),
    .valid   (IF_ID_valid)
  );

endmodule
